// File: rtl/halton_32bit_fixed.sv
// 2-D Halton point generator (bases 2 and 3). Each pop advances a 32-bit index
// and produces both radical inverses digit-serially, one digit per base per cycle.
module halton_32bit_fixed #(
   parameter int unsigned SCALE_0 = 11,
   parameter int unsigned SCALE_1 = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pop_enable,
   input  logic [31:0] seed,
   input  logic        reseed_enable,
   output logic [31:0] halton_out_0,
   output logic [31:0] halton_out_1,
   output logic        valid
);

   localparam int unsigned MAX_DIGITS = (SCALE_0 > SCALE_1) ? SCALE_0 : SCALE_1;
   localparam logic [5:0]  LAST_D = MAX_DIGITS[5:0];
   localparam logic [5:0]  S0_D   = SCALE_0[5:0];
   localparam logic [5:0]  S1_D   = SCALE_1[5:0];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Reciprocal multiply: (2^33+1)/3 gives an exact floor(x/3) for every 32-bit x.
   function automatic logic [31:0] div3(input logic [31:0] x);
      return 32'(({32'd0, x} * 64'h0000_0000_AAAA_AAAB) >> 33);
   endfunction

   function automatic logic [31:0] mod3(input logic [31:0] x);
      return x - (div3(x) * 32'd3);
   endfunction

   state_t      state_q, state_d;
   logic [31:0] count_q, count_d;
   logic [31:0] w0_q, w0_d;
   logic [31:0] w1_q, w1_d;
   logic [31:0] acc0_q, acc0_d;
   logic [31:0] acc1_q, acc1_d;
   logic [5:0]  dig_q, dig_d;
   logic [31:0] out0_q, out0_d;
   logic [31:0] out1_q, out1_d;
   logic        valid_q, valid_d;
   logic [31:0] w1_div3;
   logic [31:0] w1_mod3;

   assign w1_div3 = div3(w1_q);
   assign w1_mod3 = mod3(w1_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      acc0_d  = acc0_q;
      acc1_d  = acc1_q;
      dig_d   = dig_q;
      out0_d  = out0_q;
      out1_d  = out1_q;
      valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            // A same-cycle reseed takes priority and the pop is dropped.
            if (reseed_enable) begin
               count_d = seed;
            end else if (pop_enable) begin
               count_d = count_q + 32'd1;
               w0_d    = count_q + 32'd1;
               w1_d    = count_q + 32'd1;
               acc0_d  = 32'd0;
               acc1_d  = 32'd0;
               dig_d   = 6'd0;
               state_d = BUSY;
            end
         end

         BUSY: begin
            if (reseed_enable) begin
               count_d = seed;
            end
            if (dig_q == LAST_D) begin
               out0_d  = acc0_q;
               out1_d  = acc1_q;
               valid_d = 1'b1;
               state_d = DONE;
            end else begin
               if (dig_q < S0_D) begin
                  acc0_d = {acc0_q[30:0], w0_q[0]};
                  w0_d   = w0_q >> 1;
               end
               if (dig_q < S1_D) begin
                  acc1_d = (acc1_q * 32'd3) + w1_mod3;
                  w1_d   = w1_div3;
               end
               dig_d = dig_q + 6'd1;
            end
         end

         DONE: begin
            if (reseed_enable) begin
               count_d = seed;
            end
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // rst_n is active-high despite its name.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= IDLE;
         count_q <= 32'd0;
         w0_q    <= 32'd0;
         w1_q    <= 32'd0;
         acc0_q  <= 32'd0;
         acc1_q  <= 32'd0;
         dig_q   <= 6'd0;
         out0_q  <= 32'd0;
         out1_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         acc0_q  <= acc0_d;
         acc1_q  <= acc1_d;
         dig_q   <= dig_d;
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         valid_q <= valid_d;
      end
   end

   assign halton_out_0 = out0_q;
   assign halton_out_1 = out1_q;
   assign valid        = valid_q;

endmodule

// File: tb/tb_halton_32bit_fixed.sv
// Bench for halton_32bit_fixed: directed scenarios plus randomized pops and
// reseeds checked against a digit-reversal reference model.
module tb_halton_32bit_fixed;

   localparam int S0 = 11;
   localparam int S1 = 7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        pop_enable = 1'b0;
   logic [31:0] seed = 32'd0;
   logic        reseed_enable = 1'b0;
   logic [31:0] halton_out_0;
   logic [31:0] halton_out_1;
   logic        valid;

   int checks = 0;
   int failures = 0;
   logic [31:0] model_count = 32'd0;

   halton_32bit_fixed #(.SCALE_0(S0), .SCALE_1(S1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pop_enable(pop_enable),
      .seed(seed),
      .reseed_enable(reseed_enable),
      .halton_out_0(halton_out_0),
      .halton_out_1(halton_out_1),
      .valid(valid)
   );

   always #5 clk = ~clk;

   // Base-2 radical inverse: bit i of k lands at position S0-1-i.
   function automatic logic [31:0] ref0(input logic [31:0] k);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < S0; i++) if (k[i]) r = r | (32'd1 << (S0 - 1 - i));
      return r;
   endfunction

   // Base-3 radical inverse: digit i of k weighted by 3^(S1-1-i).
   function automatic logic [31:0] ref1(input logic [31:0] k);
      longint unsigned m, sum, pw;
      int digs[32];
      m = 64'(k);
      for (int i = 0; i < S1; i++) begin
         digs[i] = int'(m % 3);
         m = m / 3;
      end
      sum = 0;
      for (int i = 0; i < S1; i++) begin
         pw = 1;
         for (int j = 0; j < S1 - 1 - i; j++) pw = pw * 3;
         sum = sum + longint'(digs[i]) * pw;
      end
      return sum[31:0];
   endfunction

   // Pops once from IDLE; optionally reseeds while busy. Reports what it saw.
   task automatic pop_get(input bit mid_rs, input logic [31:0] mid_seed, output int lat,
                          output logic [31:0] o0, output logic [31:0] o1, output bit got,
                          output logic vld_after);
      lat = -1; o0 = 32'hx; o1 = 32'hx; got = 1'b0; vld_after = 1'bx;
      pop_enable = 1'b1;
      @(posedge clk); #1;
      pop_enable = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (mid_rs && c == 3) begin
            reseed_enable = 1'b1;
            seed = mid_seed;
         end
         @(posedge clk); #1;
         reseed_enable = 1'b0;
         if (valid === 1'b1) begin
            lat = c; o0 = halton_out_0; o1 = halton_out_1; got = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      vld_after = valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (valid !== 1'b0 || halton_out_0 !== 32'd0 || halton_out_1 !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: valid=%b out0=%0d out1=%0d required 0/0/0", valid, halton_out_0, halton_out_1);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_count = 32'd0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int c, n, last_hi;
      logic prev;
      logic [31:0] r0[5], r1[5];
      int tim[5];
      n = 0; prev = 1'b0; last_hi = -10;
      pop_enable = 1'b1;
      c = 0;
      while (n < 5 && c < 200) begin
         @(posedge clk); #1;
         c++;
         if (valid === 1'b1) begin
            checks++;
            if (prev === 1'b1) begin
               failures++;
               $display("FAIL b2b_pulse_width: valid high on consecutive cycles at cycle %0d", c);
            end else begin
               r0[n] = halton_out_0; r1[n] = halton_out_1; tim[n] = c; n++;
            end
         end
         prev = valid;
      end
      pop_enable = 1'b0;
      checks++;
      if (n != 5) begin
         failures++;
         $display("FAIL b2b_count: got %0d results required 5", n);
      end
      checks++;
      if (n > 0 && tim[0] - 1 != 12) begin
         failures++;
         $display("FAIL b2b_latency: got %0d cycles required 12", tim[0] - 1);
      end
      for (int i = 0; i < n; i++) begin
         model_count = model_count + 32'd1;
         checks++;
         if (r0[i] !== ref0(model_count) || r1[i] !== ref1(model_count)) begin
            failures++;
            $display("FAIL b2b_result%0d: got [%0d,%0d] required [%0d,%0d]", i, r0[i], r1[i],
                     ref0(model_count), ref1(model_count));
         end
      end
      @(posedge clk); #1;
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_valid_drop: valid=%b required 0", valid);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (halton_out_0 !== 32'd1280 || halton_out_1 !== 32'd1701) begin
         failures++;
         $display("FAIL b2b_hold: got [%0d,%0d] required [1280,1701]", halton_out_0, halton_out_1);
      end
   endtask

   task automatic check_pop(input string name, input logic [31:0] e0, input logic [31:0] e1,
                            input bit mid_rs, input logic [31:0] mid_seed);
      int lat; logic [31:0] o0, o1; bit got; logic va;
      pop_get(mid_rs, mid_seed, lat, o0, o1, got, va);
      checks++;
      if (!got || o0 !== e0 || o1 !== e1) begin
         failures++;
         $display("FAIL %s: got=%0b [%0d,%0d] required [%0d,%0d]", name, got, o0, o1, e0, e1);
      end
      checks++;
      if (lat != 12 || va !== 1'b0) begin
         failures++;
         $display("FAIL %s_timing: latency=%0d valid_after=%b required 12/0", name, lat, va);
      end
   endtask

   task automatic test_reseed();
      reseed_enable = 1'b1; seed = 32'd5;
      @(posedge clk); #1;
      reseed_enable = 1'b0;
      model_count = 32'd5;
      @(posedge clk); #1;
      model_count = model_count + 32'd1;
      check_pop("reseed5", 32'd768, 32'd486, 1'b0, 32'd0);
   endtask

   task automatic test_reset_reinit();
      rst_n = 1'b1;
      #3;
      checks++;
      if (valid !== 1'b0 || halton_out_0 !== 32'd0 || halton_out_1 !== 32'd0) begin
         failures++;
         $display("FAIL reinit_during_reset: valid=%b out=[%0d,%0d] required 0/[0,0]", valid, halton_out_0, halton_out_1);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_count = 32'd1;
      check_pop("reinit_pop", 32'd1024, 32'd729, 1'b0, 32'd0);
   endtask

   task automatic test_reset_midbusy();
      int seen;
      pop_enable = 1'b1;
      @(posedge clk); #1;
      pop_enable = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || halton_out_0 !== 32'd0 || halton_out_1 !== 32'd0) begin
         failures++;
         $display("FAIL midbusy_abort: valid pulses=%0d out=[%0d,%0d] required 0/[0,0]", seen, halton_out_0, halton_out_1);
      end
      model_count = 32'd1;
      check_pop("midbusy_next", 32'd1024, 32'd729, 1'b0, 32'd0);
   endtask

   task automatic test_wrap();
      reseed_enable = 1'b1; seed = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      reseed_enable = 1'b0;
      check_pop("wrap_k0", 32'd0, 32'd0, 1'b0, 32'd0);
      check_pop("wrap_k1", 32'd1024, 32'd729, 1'b0, 32'd0);
      model_count = 32'd1;
   endtask

   task automatic test_same_cycle_reseed();
      int seen;
      reseed_enable = 1'b1; seed = 32'd5; pop_enable = 1'b1;
      @(posedge clk); #1;
      reseed_enable = 1'b0; pop_enable = 1'b0;
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL same_cycle_pop_ignored: valid pulses=%0d required 0", seen);
      end
      check_pop("same_cycle_next", 32'd768, 32'd486, 1'b0, 32'd0);
      model_count = 32'd6;
   endtask

   task automatic test_random();
      logic [31:0] s, k;
      bit mid;
      for (int it = 0; it < 16; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            s = $urandom;
            reseed_enable = 1'b1; seed = s;
            @(posedge clk); #1;
            reseed_enable = 1'b0;
            model_count = s;
         end
         k = model_count + 32'd1;
         mid = ($urandom_range(0, 3) == 0);
         s = $urandom;
         check_pop("random", ref0(k), ref1(k), mid, s);
         model_count = mid ? s : k;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_reseed();
      test_reset_reinit();
      test_reset_midbusy();
      test_wrap();
      test_same_cycle_reseed();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
